// File: rtl/tpx3_status_pkg.sv
// Shared types and helpers for the FECv6 front-panel status LED block.
package tpx3_status_pkg;

  // Width of the latched lane count, pulse counter and gap counter.
  localparam int CNT_W     = 4;
  // Widest lane vector the counters are sized for.
  localparam int MAX_LANES = 15;

  // Blink-code sequencer for LED[1].
  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    GAP
  } blink_state_t;

  // Number of set bits in a (zero-extended) lane vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/tpx3_status_led_if.sv
// Link-status inputs from tpx3_sfp and LED/lane-count outputs of tpx3_status_led.
interface tpx3_status_led_if #(
  parameter int LANES = 8
);
  import tpx3_status_pkg::*;

  logic             ETH_STATUS_OK;
  logic [LANES-1:0] RX_READY;
  logic [1:0]       LED;
  logic [CNT_W-1:0] READY_CNT;

  // Driver of the status inputs (SFP core side / bench).
  modport master (
    output ETH_STATUS_OK,
    output RX_READY,
    input  LED,
    input  READY_CNT
  );

  // The LED controller itself.
  modport slave (
    input  ETH_STATUS_OK,
    input  RX_READY,
    output LED,
    output READY_CNT
  );

endinterface

// File: rtl/tpx3_tick_gen.sv
// Free-running blink tick: one-cycle pulse every TICK_DIV clock cycles.
module tpx3_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic BUS_CLK,
  input  logic BUS_RST,
  output logic TICK
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and wrap; with TICK_DIV=1 the counter sits at 0.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/tpx3_status_led.sv
// Front-panel LED driver: LED[0] = Ethernet link (solid up / blinking down),
// LED[1] = blink code of the number of receiver-ready Timepix3 lanes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a tick to latch READY_CNT and start a frame
// ON    | pulse high for one tick
// OFF   | pulse low for one tick; last pulse moves on to the gap
// GAP   | inter-frame gap; LED[1] solid if all lanes ready, else dark
module tpx3_status_led
  import tpx3_status_pkg::*;
#(
  parameter int TICK_DIV  = 12_500_000,
  parameter int LANES     = 8,
  parameter int GAP_TICKS = 6
) (
  input  logic         BUS_CLK,
  input  logic         BUS_RST,
  tpx3_status_led_if.slave status
);

  localparam logic [CNT_W-1:0] LANES_C  = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  // A one-tick gap is just the IDLE tick itself, so GAP is bypassed.
  localparam bit               GAP_SKIP = (GAP_TICKS == 1);

  logic [LANES-1:0]     rdy_m, rdy_s;
  logic                 eth_m, eth_s, eth_d;
  logic [MAX_LANES-1:0] rdy_ext;
  logic [CNT_W-1:0]     ready_cnt_q;
  logic                 led0_q;
  logic                 led1_q, led1_n;
  logic                 tick;
  blink_state_t         state_q, state_n;
  logic [CNT_W-1:0]     cur_n_q, cur_n_n;
  logic [CNT_W-1:0]     pcnt_q, pcnt_n;
  logic [CNT_W-1:0]     gcnt_q, gcnt_n;

  tpx3_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .BUS_CLK(BUS_CLK),
    .BUS_RST(BUS_RST),
    .TICK   (tick)
  );

  // Two-flop synchronisers for the asynchronous link-status inputs.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      eth_m <= 1'b0;
      eth_s <= 1'b0;
      rdy_m <= '0;
      rdy_s <= '0;
    end else begin
      eth_m <= status.ETH_STATUS_OK;
      eth_s <= eth_m;
      rdy_m <= status.RX_READY;
      rdy_s <= rdy_m;
    end
  end

  // Zero-extend the synchronised lanes for the shared popcount helper.
  always_comb begin
    rdy_ext = '0;
    rdy_ext[LANES-1:0] = rdy_s;
  end

  // Registered ready-lane count.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      ready_cnt_q <= '0;
    end else begin
      ready_cnt_q <= popcount(rdy_ext);
    end
  end

  // LED[0]: solid while link is up; on link loss go dark, then toggle per tick.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      eth_d  <= 1'b0;
      led0_q <= 1'b0;
    end else begin
      eth_d <= eth_s;
      if (eth_s) begin
        led0_q <= 1'b1;
      end else if (eth_d) begin
        led0_q <= 1'b0;
      end else if (tick) begin
        led0_q <= ~led0_q;
      end
    end
  end

  // Blink FSM state register; reset wins over a coincident tick.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q <= IDLE;
      cur_n_q <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
      led1_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cur_n_q <= cur_n_n;
      pcnt_q  <= pcnt_n;
      gcnt_q  <= gcnt_n;
      led1_q  <= led1_n;
    end
  end

  // Blink FSM next state; everything advances only on a tick.
  always_comb begin
    state_n = state_q;
    cur_n_n = cur_n_q;
    pcnt_n  = pcnt_q;
    gcnt_n  = gcnt_q;
    led1_n  = led1_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          cur_n_n = ready_cnt_q;
          pcnt_n  = '0;
          gcnt_n  = '0;
          if (ready_cnt_q == '0) begin
            state_n = GAP_SKIP ? IDLE : GAP;
            led1_n  = 1'b0;
          end else if (ready_cnt_q == LANES_C) begin
            state_n = GAP_SKIP ? IDLE : GAP;
            led1_n  = 1'b1;
          end else begin
            state_n = ON;
            led1_n  = 1'b1;
          end
        end
        ON: begin
          state_n = OFF;
          led1_n  = 1'b0;
          pcnt_n  = pcnt_q + CNT_W'(1);
        end
        OFF: begin
          if (pcnt_q == cur_n_q) begin
            state_n = GAP_SKIP ? IDLE : GAP;
            gcnt_n  = '0;
          end else begin
            state_n = ON;
            led1_n  = 1'b1;
          end
        end
        GAP: begin
          // LED[1] is simply held: solid for all-ready, dark otherwise.
          if (gcnt_q + CNT_W'(1) == GAP_LAST) begin
            state_n = IDLE;
          end else begin
            gcnt_n = gcnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign status.LED       = {led1_q, led0_q};
  assign status.READY_CNT = ready_cnt_q;

endmodule

// File: tb/tb_tpx3_status_led.sv
// Self-checking bench for tpx3_status_led (TICK_DIV=4, GAP_TICKS=3, LANES=8).
module tb_tpx3_status_led;

  localparam int TICK_DIV  = 4;
  localparam int LANES     = 8;
  localparam int GAP_TICKS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  tpx3_status_led_if #(.LANES(LANES)) bus();

  tpx3_status_led #(
    .TICK_DIV (TICK_DIV),
    .LANES    (LANES),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .BUS_CLK(clk),
    .BUS_RST(rst),
    .status (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Inputs seen at each edge are kept in a short history; an input needs two
  // edges to cross the synchroniser. LED[1] is modelled as a queue of per-tick
  // levels: a frame of n pulses is [1,0]*n followed by GAP_TICKS dark ticks
  // (or GAP_TICKS solid ticks when all lanes are ready).
  typedef struct packed {
    logic             eth;
    logic [LANES-1:0] rdy;
  } smp_t;

  smp_t     hq[$];
  int       m_edges = 0;
  logic [3:0] m_cnt = '0;
  logic     m_led0 = 1'b0;
  logic     m_led1 = 1'b0;
  bit       m_valid = 1'b0;
  bit       pat[$];

  always @(posedge clk) begin : model
    smp_t       cur;
    logic       eth_s, eth_d, tk;
    logic [3:0] cnt_prev;
    int         sz;
    cur.eth = bus.ETH_STATUS_OK;
    cur.rdy = bus.RX_READY;
    if (rst) begin
      hq.delete();
      repeat (3) hq.push_back('0);
      m_edges = 0;
      m_cnt   = '0;
      m_led0  = 1'b0;
      m_led1  = 1'b0;
      pat.delete();
      m_valid = 1'b1;
    end else begin
      hq.push_back(cur);
      if (hq.size() > 4) void'(hq.pop_front());
      sz       = hq.size();
      eth_s    = hq[sz-3].eth;
      eth_d    = hq[sz-4].eth;
      cnt_prev = m_cnt;
      m_cnt    = 4'($countones(hq[sz-3].rdy));
      m_edges++;
      tk = ((m_edges % TICK_DIV) == 0);
      if (eth_s)      m_led0 = 1'b1;
      else if (eth_d) m_led0 = 1'b0;
      else if (tk)    m_led0 = ~m_led0;
      if (tk) begin
        if (pat.size() == 0) begin
          if (cnt_prev == 0) begin
            repeat (GAP_TICKS) pat.push_back(1'b0);
          end else if (cnt_prev == LANES) begin
            repeat (GAP_TICKS) pat.push_back(1'b1);
          end else begin
            repeat (int'(cnt_prev)) begin
              pat.push_back(1'b1);
              pat.push_back(1'b0);
            end
            repeat (GAP_TICKS) pat.push_back(1'b0);
          end
        end
        m_led1 = pat.pop_front();
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (m_valid) begin
      tests++;
      if (bus.LED !== {m_led1, m_led0} || bus.READY_CNT !== m_cnt) begin
        fails++;
        $display("FAIL model t=%0t: LED=%b READY_CNT=%0d, expected LED=%b READY_CNT=%0d",
                 $time, bus.LED, bus.READY_CNT, {m_led1, m_led0}, m_cnt);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       eth;
    logic [7:0] rdy;
    int         exp_cnt;
    int         win;
    int         exp_h0;
    int         exp_h1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   h0, h1, ntr, last_t, found;
    logic prev;

    // Frame period P = (2n+GAP_TICKS)*TICK_DIV for partial n; window = 2P.
    vecs[0] = '{1'b1, 8'h07, 3,  72,  72, 24};
    vecs[1] = '{1'b0, 8'h00, 0,  24,  12,  0};
    vecs[2] = '{1'b1, 8'hFF, 8,  24,  24, 24};
    vecs[3] = '{1'b0, 8'h01, 1,  40,  20,  8};
    vecs[4] = '{1'b1, 8'hA5, 4,  88,  88, 32};
    vecs[5] = '{1'b0, 8'hFE, 7, 136,  68, 56};

    // Reset with all inputs high.
    rst = 1'b1;
    bus.ETH_STATUS_OK = 1'b1;
    bus.RX_READY      = 8'hFF;
    repeat (3) begin
      step();
      chk("rst_led", int'(bus.LED), 0);
      chk("rst_cnt", int'(bus.READY_CNT), 0);
    end
    rst = 1'b0;
    step(); chk("cnt_lat1", int'(bus.READY_CNT), 0);
    step(); chk("cnt_lat2", int'(bus.READY_CNT), 0);
    step(); chk("cnt_lat3", int'(bus.READY_CNT), 8);
    repeat (20) begin
      step();
      h1 = int'(bus.LED[1]);
    end
    chk("all_ready_solid", h1, 1);

    // Link down: LED[0] toggles every TICK_DIV cycles.
    bus.ETH_STATUS_OK = 1'b0;
    bus.RX_READY      = 8'h00;
    repeat (4) step();
    prev   = bus.LED[0];
    ntr    = 0;
    last_t = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.LED[0] !== prev) begin
        if (last_t >= 0) chk("eth_down_interval", i - last_t, TICK_DIV);
        last_t = i;
        ntr++;
      end
      prev = bus.LED[0];
    end
    chk("eth_down_toggles", ntr, 10);

    // Link back up: solid within 3 cycles and stays solid.
    bus.ETH_STATUS_OK = 1'b1;
    repeat (3) step();
    chk("eth_up_3cyc", int'(bus.LED[0]), 1);
    h0 = 0;
    repeat (16) begin
      step();
      if (bus.LED[0] !== 1'b1) h0++;
    end
    chk("eth_up_hold", h0, 0);

    // Static lane patterns from reset: count and duty over two frames.
    for (int v = 0; v < 6; v++) begin
      bus.ETH_STATUS_OK = vecs[v].eth;
      bus.RX_READY      = vecs[v].rdy;
      pulse_reset();
      repeat (3) step();
      h0 = 0;
      h1 = 0;
      for (int i = 0; i < vecs[v].win; i++) begin
        step();
        h0 += int'(bus.LED[0]);
        h1 += int'(bus.LED[1]);
      end
      chk($sformatf("vec%0d_cnt", v), int'(bus.READY_CNT), vecs[v].exp_cnt);
      chk($sformatf("vec%0d_led0_high", v), h0, vecs[v].exp_h0);
      chk($sformatf("vec%0d_led1_high", v), h1, vecs[v].exp_h1);
    end

    // 8'h07 -> 8'h01 during the 2nd pulse: frame finishes 3 pulses, next has 1.
    bus.ETH_STATUS_OK = 1'b1;
    bus.RX_READY      = 8'h07;
    pulse_reset();
    repeat (3) step();
    h1 = 0;
    for (int e = 4; e < 40; e++) begin
      step();
      h1 += int'(bus.LED[1]);
      if (e == 13) bus.RX_READY = 8'h01;
    end
    chk("midframe_frame1_high", h1, 12);
    h1 = 0;
    for (int e = 40; e < 60; e++) begin
      step();
      h1 += int'(bus.LED[1]);
    end
    chk("midframe_frame2_high", h1, 4);

    // Reset during an ON pulse.
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      if (bus.LED[1] === 1'b1) found = 1;
    end
    chk("wait_on_state", found, 1);
    rst = 1'b1;
    step();
    chk("rst_mid_led", int'(bus.LED), 0);
    chk("rst_mid_cnt", int'(bus.READY_CNT), 0);
    rst = 1'b0;
    h1 = 0;
    repeat (3) begin
      step();
      h1 += int'(bus.LED[1]);
    end
    chk("rst_mid_dark_before_tick", h1, 0);
    step();
    chk("rst_mid_first_pulse", int'(bus.LED[1]), 1);

    // Randomised segments checked cycle by cycle against the model.
    for (int s = 0; s < 30; s++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       bus.RX_READY = 8'h00;
        1:       bus.RX_READY = 8'hFF;
        default: bus.RX_READY = 8'($urandom);
      endcase
      bus.ETH_STATUS_OK = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) pulse_reset();
      repeat ($urandom_range(10, 150)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
